// File: rtl/framebuffer_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : framebuffer_arbiter
// Purpose  : Shares one asynchronous single-port pixel SRAM between the
//            display read path and the capture write path. Reads win during
//            the active area (with a write starvation guard), writes win during
//            blanking. Sequences strobes, address/data hold and bus turnaround.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 12,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_blank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    // Counter value of the final cycle of an access, and the starvation cap.
    localparam logic [3:0] C_LAST_CYCLE   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] C_STARVE_MAX   = 4'hF;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] r_starve_cnt;
    logic       w_access_end;
    logic       w_decide;
    logic       w_wr_wins;
    logic       w_rd_wins;
    logic       w_grant_rd;
    logic       w_grant_wr;

    // Arbitration, next state and strobe decode. A direction change from an
    // active access detours through TURN; from IDLE or TURN the bus is already
    // quiet, so the winner is granted directly.
    always_comb begin
        w_next_state = r_state;
        w_grant_rd   = 1'b0;
        w_grant_wr   = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        busy         = (r_state != ST_IDLE);

        w_access_end = ((r_state == ST_RD) || (r_state == ST_WR)) &&
                       (r_cnt == C_LAST_CYCLE);
        w_decide     = (r_state == ST_IDLE) || (r_state == ST_TURN) || w_access_end;
        w_wr_wins    = wr_req && (!rd_req || in_blank ||
                                  (r_starve_cnt == C_STARVE_LIMIT));
        w_rd_wins    = rd_req && !w_wr_wins;

        if (w_decide) begin
            if (w_wr_wins) begin
                if (r_state == ST_RD) begin
                    w_next_state = ST_TURN;
                end else begin
                    w_next_state = ST_WR;
                    w_grant_wr   = 1'b1;
                end
            end else if (w_rd_wins) begin
                if (r_state == ST_WR) begin
                    w_next_state = ST_TURN;
                end else begin
                    w_next_state = ST_RD;
                    w_grant_rd   = 1'b1;
                end
            end else begin
                w_next_state = ST_IDLE;
            end
        end

        case (r_state)
            ST_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            ST_WR: begin
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State register; async reset drops strobes at once via the decode above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Access cycle counter: restarts on every grant, stops at the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_grant_rd || w_grant_wr) begin
            r_cnt <= 4'd0;
        end else if (((r_state == ST_RD) || (r_state == ST_WR)) &&
                     (r_cnt != C_LAST_CYCLE)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Count reads granted over a waiting write; saturates, clears on relief.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!wr_req || w_grant_wr) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_rd && (r_starve_cnt != C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Latch address/data at grant and pulse the matching ack for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_ack     <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            rd_ack <= w_grant_rd;
            wr_ack <= w_grant_wr;
            if (w_grant_rd) begin
                sram_addr <= rd_addr;
            end
            if (w_grant_wr) begin
                sram_addr  <= wr_addr;
                sram_wdata <= wr_data;
            end
        end
    end

    // Capture SRAM data at the edge ending the last read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (r_state == ST_RD) && w_access_end;
            if ((r_state == ST_RD) && w_access_end) begin
                rd_data <= sram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_arbiter
// Purpose  : Self-checking bench for framebuffer_arbiter. Directed scenarios
//            plus random traffic, checked slot by slot against a timeline
//            model of bus ownership and a reference pixel memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int AC     = 2;
    localparam int SL     = 4;
    localparam int NSLOT  = 4096;
    localparam int M_NONE = 0;
    localparam int M_RD   = 1;
    localparam int M_WR   = 2;
    localparam int M_TURN = 3;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_blank = 1'b0;
    logic              rd_req   = 1'b0;
    logic [ADDR_W-1:0] rd_addr  = '0;
    logic              wr_req   = 1'b0;
    logic [ADDR_W-1:0] wr_addr  = '0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              rd_ack, rd_valid, wr_ack, busy;
    logic [DATA_W-1:0] rd_data, sram_wdata, sram_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n, sram_oe_n, sram_we_n;

    framebuffer_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_blank(in_blank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Background pixel pattern so unwritten locations hold distinct values.
    function automatic logic [DATA_W-1:0] bg(input int a);
        return 12'hABC ^ 12'((a ^ 5) * 241);
    endfunction

    // SRAM model: 64 words aliased on the low address bits.
    logic [DATA_W-1:0] mem [64] = '{default: '0};
    assign sram_rdata = mem[sram_addr[5:0]] ^ bg(int'(sram_addr[5:0]));
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_wdata ^ bg(int'(sram_addr[5:0]));
    end

    // Reference model state and per-slot expectations.
    logic [DATA_W-1:0] ref_mem   [64];
    int                exp_mode  [NSLOT];
    logic              exp_rack  [NSLOT];
    logic              exp_wack  [NSLOT];
    logic              exp_valid [NSLOT];
    logic [ADDR_W-1:0] exp_addr  [NSLOT];
    logic [DATA_W-1:0] exp_wdata [NSLOT];
    logic [DATA_W-1:0] exp_data  [NSLOT];
    int m_busy_until = 0;
    int m_end_dir    = M_NONE;
    int m_starve     = 0;

    logic [ADDR_W-1:0] rd_q [$];
    logic [ADDR_W-1:0] wa_q [$];
    logic [DATA_W-1:0] wd_q [$];

    int ec = 0;
    int n_assert = 0;
    int n_fail = 0;
    int n_rd_acks = 0;
    int rbw = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, ec, got, exp);
        end
    endtask

    task automatic clear_from(input int s0);
        for (int s = s0; s < NSLOT; s++) begin
            exp_mode[s] = M_NONE; exp_rack[s] = 1'b0; exp_wack[s] = 1'b0;
            exp_valid[s] = 1'b0; exp_addr[s] = '0; exp_wdata[s] = '0; exp_data[s] = '0;
        end
    endtask

    // Timeline model: the bus is owned until m_busy_until; at or after that
    // edge the spec's priority rules choose the next owner.
    task automatic model_edge(input int e);
        int win;
        int granted;
        logic [ADDR_W-1:0] a;
        win = M_NONE;
        granted = M_NONE;
        if (!rst_n || (e + AC + 1 >= NSLOT)) return;
        if (e >= m_busy_until) begin
            if (wr_req && (!rd_req || in_blank || m_starve == SL)) win = M_WR;
            else if (rd_req) win = M_RD;
            if (win == M_NONE) begin
                m_end_dir = M_NONE;
            end else if (m_end_dir != M_NONE && m_end_dir != win) begin
                exp_mode[e] = M_TURN;
                m_busy_until = e + 1;
                m_end_dir = M_NONE;
            end else begin
                granted = win;
                a = (win == M_RD) ? rd_addr : wr_addr;
                if (win == M_RD) begin
                    exp_rack[e] = 1'b1;
                    exp_valid[e + AC] = 1'b1;
                    exp_data[e + AC] = ref_mem[rd_addr[5:0]];
                end else begin
                    exp_wack[e] = 1'b1;
                    ref_mem[wr_addr[5:0]] = wr_data;
                end
                for (int s = e; s < e + AC; s++) begin
                    exp_mode[s] = win; exp_addr[s] = a; exp_wdata[s] = wr_data;
                end
                m_busy_until = e + AC;
                m_end_dir = win;
            end
        end
        if (!wr_req || granted == M_WR) m_starve = 0;
        else if (granted == M_RD && m_starve < 15) m_starve++;
    endtask

    task automatic check_slot(input int s);
        int m;
        logic [2:0] st;
        if (s >= NSLOT) return;
        m = exp_mode[s];
        st = (m == M_RD) ? 3'b001 : (m == M_WR) ? 3'b010 : 3'b111;
        chk("rd_ack", 32'(rd_ack), 32'(exp_rack[s]));
        chk("wr_ack", 32'(wr_ack), 32'(exp_wack[s]));
        chk("rd_valid", 32'(rd_valid), 32'(exp_valid[s]));
        chk("busy", 32'(busy), 32'(m != M_NONE));
        chk("strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(st));
        if (m == M_RD || m == M_WR) chk("sram_addr", 32'(sram_addr), 32'(exp_addr[s]));
        if (m == M_WR) chk("sram_wdata", 32'(sram_wdata), 32'(exp_wdata[s]));
        if (exp_valid[s]) chk("rd_data", 32'(rd_data), 32'(exp_data[s]));
    endtask

    // Requesters present the head of their queue and hold it until acked.
    task automatic present();
        if (!rd_req && rd_q.size() != 0) begin rd_req = 1'b1; rd_addr = rd_q[0]; end
        if (!wr_req && wa_q.size() != 0) begin wr_req = 1'b1; wr_addr = wa_q[0]; wr_data = wd_q[0]; end
    endtask

    task automatic handle_acks();
        logic [ADDR_W-1:0] ta;
        logic [DATA_W-1:0] td;
        if (rd_req && rd_ack) begin ta = rd_q.pop_front(); rd_req = 1'b0; end
        if (wr_req && wr_ack) begin ta = wa_q.pop_front(); td = wd_q.pop_front(); wr_req = 1'b0; end
    endtask

    task automatic tick();
        @(posedge clk);
        ec++;
        model_edge(ec);
        @(negedge clk);
        check_slot(ec);
        if (rd_ack) n_rd_acks++;
        if (wr_ack && rbw < 0) rbw = n_rd_acks;
        handle_acks();
        present();
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((rd_q.size() != 0 || wa_q.size() != 0 || busy) && t < 300) begin
            tick();
            t++;
        end
        chk(tag, 32'(t < 300), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = bg(i);
        clear_from(0);

        // Reset values
        #1;
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single read of 0x12345 (SRAM word holds 0xABC)
        rd_q.push_back(19'h12345); present();
        drain("single_read");

        // Three back-to-back reads
        rd_q.push_back(19'h00010); rd_q.push_back(19'h00011); rd_q.push_back(19'h00012);
        present();
        drain("burst_read");

        // Active-area contention: reads held, one write waits for the guard
        in_blank = 1'b0;
        n_rd_acks = 0; rbw = -1;
        for (int i = 0; i < 8; i++) rd_q.push_back(19'(32'h20 + i));
        wa_q.push_back(19'h00030); wd_q.push_back(12'h111);
        present();
        drain("contention");
        chk("reads_before_write", 32'(rbw), 32'(SL));

        // Blanking: write beats a simultaneous read
        in_blank = 1'b1;
        rd_q.push_back(19'h00007); wa_q.push_back(19'h00008); wd_q.push_back(12'h3C3);
        present();
        drain("blank_priority");

        // Write 0x5A5 to 0x42 then read it back through a turnaround
        wa_q.push_back(19'h00042); wd_q.push_back(12'h5A5); present();
        tick();
        rd_q.push_back(19'h00042); present();
        drain("write_then_read");

        // Reset during the first cycle of a read
        in_blank = 1'b0;
        rd_q.push_back(19'h00077); present();
        begin
            int t;
            t = 0;
            while (!rd_ack && t < 20) begin tick(); t++; end
            chk("reset_read_granted", 32'(rd_ack), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        clear_from(ec);
        m_busy_until = 0; m_end_dir = M_NONE; m_starve = 0;
        chk("reset_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_ack", 32'(rd_ack), 32'd0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        rd_q.push_back(19'h00078); present();
        drain("post_reset_read");

        // Random traffic with in_blank wandering
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) in_blank = ~in_blank;
            if (rd_q.size() < 3 && $urandom_range(0, 2) == 0) rd_q.push_back(19'($urandom));
            if (wa_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                wa_q.push_back(19'($urandom));
                wd_q.push_back(12'($urandom));
            end
            present();
            tick();
        end
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
